vc_round_robin_merge: RTL and testbench
=======================================

// Module: vc_round_robin_merge
// PURPOSE
// - Transmit-side counterpart of the per-VC output demux: merges four virtual-channel FIFO heads into one 12-bit stream.
// - Sits between the four VC FIFOs (first-word-fall-through) and the downstream link FIFO.
// - Fair round-robin arbitration; honours downstream almost-full; checks that each word's VC tag matches its source FIFO.
// PARAMETERS
// - DATA_W   12   word width; VC tag at [VC_LSB+1:VC_LSB]
// - VC_LSB   8    LSB of the 2-bit VC tag inside a word
// PORTS
// - clk          in   1       single clock, all logic on posedge
// - reset_L      in   1       synchronous, active-low reset
// - states       in   4       one-hot controller state; 4'b0001 = INIT (block held cleared)
// - data0..data3 in   DATA_W  head word of VC FIFO 0..3 (valid while emptyN=0)
// - empty0..3    in   1       VC FIFO N empty
// - almost_full  in   1       downstream FIFO cannot accept more words
// - pop0..pop3   out  1       combinational pop to VC FIFO N
// - data_out     out  DATA_W  merged word (registered)
// - valid_out    out  1       data_out valid / push to downstream (registered)
// - vc_err       out  1       sticky: a popped word's tag != source VC
// - last_vc      out  2       VC index of most recent grant
// BEHAVIOUR
// - Reset (reset_L=0 at posedge) and states==4'b0001 behave identically:
//   data_out=0, valid_out=0, vc_err=0, last_vc=2'd3, FSM->IDLE; pops all 0 that cycle.
// - FSM: IDLE -> RUN when reset_L=1 and states!=INIT.
//   RUN -> STALL when almost_full=1; STALL -> RUN when almost_full=0.
//   Any state -> IDLE on reset or INIT.
// - Grant (RUN only, almost_full=0): search VCs in order last_vc+1, +2, +3, +4 (mod 4);
//   first with emptyN=0 wins. At most one popN=1 per cycle. No grant if all empty.
// - pop is combinational from registered FSM/last_vc plus current empty/almost_full; no pop in IDLE/STALL.
// - On grant of VC k at posedge: data_out<=data_k, valid_out<=1, last_vc<=k.
//   If data_k[VC_LSB+1:VC_LSB]!=k then vc_err<=1 (word still forwarded).
// - No grant: valid_out<=0, data_out holds, last_vc holds.
// - Latency: word at FIFO head with pop asserted appears on data_out exactly 1 cycle later.
// - almost_full rising in the same cycle as a candidate grant: no pop that cycle (stall wins).
// - Single non-empty VC: granted every cycle (back-to-back, 100% throughput).
// - Pointer wraps 3->0; last_vc only moves on a real grant.
// - INIT/reset mid-stream: the word popped in the previous cycle still drives data_out until this posedge,
//   then is cleared; no further pops until INIT is left.
// STRUCTURE
// - Shared package/header: state one-hot constants (INIT=4'b0001), FSM encodings IDLE/RUN/STALL,
//   VC tag field position (VC_LSB), NUM_VC=4.
// - One sub-module: rr_arbiter4 (req[3:0], last[1:0] -> gnt[3:0] one-hot, gnt_idx[1:0]), purely combinational.
//   Top holds FSM, output registers, and the error flag.
// TESTING
// - Reset: reset_L=0, all FIFOs non-empty -> pops 0, data_out=0, valid_out=0, last_vc=3, vc_err=0.
// - Fairness: all four non-empty, data0..3 = 12'h0AA/1BB/2CC/3DD -> data_out sequence 0AA,1BB,2CC,3DD,0AA...,
//   valid_out=1 every cycle.
// - Sparse: only VC2 non-empty with 12'h2F0 for 5 cycles -> pop2=1 each cycle, 5 consecutive 2F0 outputs.
// - Backpressure: almost_full=1 for 3 cycles mid-stream -> pops 0, valid_out=0 from next cycle;
//   resumes at next VC after last_vc with no skipped or duplicated word.
// - Tag error: empty1=0, data1=12'h300 -> word forwarded, vc_err=1 and stays 1 until reset/INIT.
// - INIT mid-stream: states=4'b0001 for one cycle -> outputs cleared, last_vc=3;
//   after release, first grant goes to VC0.

Source files
------------

// File: rtl/vc_round_robin_merge_pkg.sv
// Shared constants and types for the four-VC round-robin merge.
package vc_round_robin_merge_pkg;
  localparam int          NUM_VC     = 4;
  localparam int          VC_LSB_DEF = 8;
  localparam logic [3:0]  ST_INIT    = 4'b0001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } merge_fsm_e;
endpackage

// File: rtl/vc_round_robin_merge_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: search starts just after 'last'.
module rr_arbiter4
  import vc_round_robin_merge_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);
  logic [1:0] w_idx;
  logic       w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = last;
    w_found = 1'b0;
    w_idx   = last;
    // offset 4 wraps to 'last' itself, so a lone requester is always served
    for (int o = 1; o <= NUM_VC; o++) begin
      w_idx = last + 2'(o);
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = w_idx;
      end
    end
  end
endmodule

// File: rtl/vc_round_robin_merge.sv
// Merges four FWFT VC FIFO heads into one registered stream with fair arbitration.
module vc_round_robin_merge
  import vc_round_robin_merge_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int VC_LSB = VC_LSB_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [3:0]        states,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  input  logic              empty0,
  input  logic              empty1,
  input  logic              empty2,
  input  logic              empty3,
  input  logic              almost_full,
  output logic              pop0,
  output logic              pop1,
  output logic              pop2,
  output logic              pop3,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              vc_err,
  output logic [1:0]        last_vc
);
  merge_fsm_e        r_state, w_state_nxt;
  logic [3:0]        w_req, w_gnt, w_pop;
  logic [1:0]        w_gnt_idx;
  logic              w_clear, w_en, w_any;
  logic [DATA_W-1:0] w_data [NUM_VC];
  logic [DATA_W-1:0] w_sel;

  assign w_req    = ~{empty3, empty2, empty1, empty0};
  assign w_clear  = !reset_L || (states == ST_INIT);
  // stall wins: almost_full suppresses the pop in the very cycle it rises
  assign w_en     = (r_state == RUN) && !almost_full && !w_clear;
  assign w_pop    = w_en ? w_gnt : 4'b0000;
  assign w_any    = |w_pop;
  assign {pop3, pop2, pop1, pop0} = w_pop;

  assign w_data[0] = data0;
  assign w_data[1] = data1;
  assign w_data[2] = data2;
  assign w_data[3] = data3;
  assign w_sel     = w_data[w_gnt_idx];

  rr_arbiter4 u_arb (
    .req     (w_req),
    .last    (last_vc),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = RUN;
      RUN:     if (almost_full)  w_state_nxt = STALL;
      STALL:   if (!almost_full) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
    if (w_clear) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    r_state <= w_state_nxt;
    if (w_clear) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      vc_err    <= 1'b0;
      last_vc   <= 2'd3;
    end else if (w_any) begin
      data_out  <= w_sel;
      valid_out <= 1'b1;
      last_vc   <= w_gnt_idx;
      if (w_sel[VC_LSB+1:VC_LSB] != w_gnt_idx) vc_err <= 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vc_round_robin_merge.sv
// Self-checking bench: directed table, hand sequences and random traffic vs a reference model.
module tb_vc_round_robin_merge;
  logic        clk, reset_L, almost_full;
  logic [3:0]  states;
  logic [11:0] data0, data1, data2, data3, data_out;
  logic        empty0, empty1, empty2, empty3;
  logic        pop0, pop1, pop2, pop3, valid_out, vc_err;
  logic [1:0]  last_vc;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [11:0] m_data;
  logic        m_valid, m_err;
  int          m_last;
  bit          m_idle = 1;   // previous cycle was a clear cycle
  bit          m_hold = 0;   // previous cycle was an active cycle with almost_full high

  vc_round_robin_merge dut (
    .clk(clk), .reset_L(reset_L), .states(states),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .empty0(empty0), .empty1(empty1), .empty2(empty2), .empty3(empty3),
    .almost_full(almost_full),
    .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
    .data_out(data_out), .valid_out(valid_out), .vc_err(vc_err), .last_vc(last_vc)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check pops mid-cycle, then registered outputs after the edge.
  task automatic cyc(input bit rst_l, input logic [3:0] st, input logic [3:0] emp, input bit af,
                     output logic [3:0] pop_seen);
    bit clear, allow;
    int win;
    logic [11:0] d [4];
    logic [3:0] epop;
    reset_L = rst_l; states = st; almost_full = af;
    {empty3, empty2, empty1, empty0} = emp;
    d[0] = data0; d[1] = data1; d[2] = data2; d[3] = data3;
    clear = !rst_l || (st == 4'b0001);
    allow = !clear && !m_idle && !af && !m_hold;
    win = -1;
    if (allow)
      for (int o = 1; o <= 4; o++)
        if (win < 0 && !emp[(m_last + o) % 4]) win = (m_last + o) % 4;
    epop = (win >= 0) ? (4'b0001 << win) : 4'b0000;
    #4;
    pop_seen = {pop3, pop2, pop1, pop0};
    chk("pop", pop_seen, epop);
    if (clear) begin
      m_data = 0; m_valid = 0; m_err = 0; m_last = 3;
    end else if (win >= 0) begin
      m_data = d[win]; m_valid = 1; m_last = win;
      if (d[win][9:8] != win[1:0]) m_err = 1;
    end else m_valid = 0;
    m_hold = !clear && !m_idle && af;
    m_idle = clear;
    @(posedge clk); #1;
    chk("valid_out", valid_out, m_valid);
    chk("data_out", data_out, m_data);
    chk("last_vc", last_vc, m_last);
    chk("vc_err", vc_err, m_err);
  endtask

  typedef struct {
    bit         rst_l;
    logic [3:0] st;
    logic [3:0] emp;
    bit         af;
    logic [3:0] pop;
    bit         valid;
    logic [11:0] dout;
    logic [1:0] last;
  } vec_t;

  vec_t tbl[14];
  logic [3:0] p;

  initial begin
    tbl[0]  = '{0, 4'b0010, 4'b0000, 0, 4'b0000, 0, 12'h000, 2'd3};
    tbl[1]  = '{1, 4'b0010, 4'b0000, 0, 4'b0000, 0, 12'h000, 2'd3};
    tbl[2]  = '{1, 4'b0010, 4'b0000, 0, 4'b0001, 1, 12'h0AA, 2'd0};
    tbl[3]  = '{1, 4'b0010, 4'b0000, 0, 4'b0010, 1, 12'h1BB, 2'd1};
    tbl[4]  = '{1, 4'b0010, 4'b0000, 0, 4'b0100, 1, 12'h2CC, 2'd2};
    tbl[5]  = '{1, 4'b0010, 4'b0000, 0, 4'b1000, 1, 12'h3DD, 2'd3};
    tbl[6]  = '{1, 4'b0010, 4'b0000, 0, 4'b0001, 1, 12'h0AA, 2'd0};
    tbl[7]  = '{1, 4'b0010, 4'b0000, 1, 4'b0000, 0, 12'h0AA, 2'd0};
    tbl[8]  = '{1, 4'b0010, 4'b0000, 0, 4'b0000, 0, 12'h0AA, 2'd0};
    tbl[9]  = '{1, 4'b0010, 4'b0000, 0, 4'b0010, 1, 12'h1BB, 2'd1};
    tbl[10] = '{1, 4'b0010, 4'b1101, 0, 4'b0010, 1, 12'h1BB, 2'd1};
    tbl[11] = '{1, 4'b0001, 4'b0000, 0, 4'b0000, 0, 12'h000, 2'd3};
    tbl[12] = '{1, 4'b0010, 4'b0000, 0, 4'b0000, 0, 12'h000, 2'd3};
    tbl[13] = '{1, 4'b0010, 4'b0000, 0, 4'b0001, 1, 12'h0AA, 2'd0};

    reset_L = 0; states = 4'b0010; almost_full = 0;
    {empty3, empty2, empty1, empty0} = 4'b0000;
    data0 = 12'h0AA; data1 = 12'h1BB; data2 = 12'h2CC; data3 = 12'h3DD;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].rst_l, tbl[i].st, tbl[i].emp, tbl[i].af, p);
      chk($sformatf("tbl%0d_pop", i), p, tbl[i].pop);
      chk($sformatf("tbl%0d_valid", i), valid_out, tbl[i].valid);
      chk($sformatf("tbl%0d_data", i), data_out, tbl[i].dout);
      chk($sformatf("tbl%0d_last", i), last_vc, tbl[i].last);
    end

    // sparse: only VC2 holds words, served back-to-back
    data2 = 12'h2F0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 4'b0010, 4'b1011, 0, p);
      chk("sparse_pop2", p, 4'b0100);
      chk("sparse_data", data_out, 12'h2F0);
      chk("sparse_valid", valid_out, 1'b1);
    end

    // tag error on VC1 is sticky until a clear
    data1 = 12'h300;
    cyc(1, 4'b0010, 4'b1101, 0, p);
    chk("tagerr_data", data_out, 12'h300);
    chk("tagerr_flag", vc_err, 1'b1);
    data1 = 12'h1BB;
    for (int i = 0; i < 3; i++) cyc(1, 4'b0010, 4'b0000, 0, p);
    chk("tagerr_sticky", vc_err, 1'b1);
    cyc(0, 4'b0010, 4'b0000, 0, p);
    chk("tagerr_cleared", vc_err, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      data0 = {2'($urandom), ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'd0, 8'($urandom)};
      data1 = {2'($urandom), ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'd1, 8'($urandom)};
      data2 = {2'($urandom), ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'd2, 8'($urandom)};
      data3 = {2'($urandom), ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'd3, 8'($urandom)};
      cyc(($urandom_range(0, 49) != 0),
          ($urandom_range(0, 39) == 0) ? 4'b0001 : 4'b0010,
          4'($urandom),
          ($urandom_range(0, 9) < 3), p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
